// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1-to-2 buffered router.
// Used by demux_fifo and demux_1_to_2_buf.
package demux_pkg;

    localparam logic CH1_SEL = 1'b0;
    localparam logic CH2_SEL = 1'b1;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 4;

    localparam int STAT_W = 32;

    typedef enum logic {
        CH1 = CH1_SEL,
        CH2 = CH2_SEL
    } channel_e;

    // Saturating increment for the statistics counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
        return (&value) ? value : value + STAT_W'(1);
    endfunction

endpackage

// File: rtl/demux_fifo.sv
// Parameterised synchronous FIFO with head-of-queue data output.
// Head data reads as zero whenever the FIFO is empty.
module demux_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: storage has no reset; the count alone decides what is valid, so
    // clearing the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/demux_1_to_2_buf.sv
// Registered 1-to-2 router: one producer stream steered by Select into two
// independent FIFOs. Optional statistics ports under DEMUX_1_TO_2_BUF_STATS_EN.
module demux_1_to_2_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               Select,
    input  logic [WIDTH-1:0]   Data_i,
    input  logic               Valid_i,
    output logic               Ready_i,
    output logic [WIDTH-1:0]   Data_o1,
    output logic               Valid_o1,
    input  logic               Ready_o1,
    output logic [WIDTH-1:0]   Data_o2,
    output logic               Valid_o2,
    input  logic               Ready_o2
`ifdef DEMUX_1_TO_2_BUF_STATS_EN
    ,
    output logic [STAT_W-1:0]  Count_o1,
    output logic [STAT_W-1:0]  Count_o2,
    output logic [STAT_W-1:0]  Stall_o
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    channel_e       sel_ch;
    logic           push;
    logic           push1;
    logic           push2;
    logic           pop1;
    logic           pop2;
    logic           full1;
    logic           full2;
    logic           empty1;
    logic           empty2;
    logic [CW-1:0]  count1;
    logic [CW-1:0]  count2;

    assign sel_ch = channel_e'(Select);

    // Ready depends only on Select and registered FIFO state, never on the
    // consumer readies, so a pop on a full channel cannot admit a push.
    assign Ready_i = (sel_ch == CH2) ? !full2 : !full1;

    assign push  = Valid_i && Ready_i;
    assign push1 = push && (sel_ch == CH1);
    assign push2 = push && (sel_ch == CH2);

    assign pop1 = Ready_o1 && !empty1;
    assign pop2 = Ready_o2 && !empty2;

    assign Valid_o1 = (count1 != '0);
    assign Valid_o2 = (count2 != '0);

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push1),
        .push_data (Data_i),
        .pop       (pop1),
        .full      (full1),
        .empty     (empty1),
        .count     (count1),
        .head_data (Data_o1)
    );

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push2),
        .push_data (Data_i),
        .pop       (pop2),
        .full      (full2),
        .empty     (empty2),
        .count     (count2),
        .head_data (Data_o2)
    );

`ifdef DEMUX_1_TO_2_BUF_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Count_o1 <= '0;
            Count_o2 <= '0;
            Stall_o  <= '0;
        end else begin
            if (pop1) begin
                Count_o1 <= sat_inc(Count_o1);
            end
            if (pop2) begin
                Count_o2 <= sat_inc(Count_o2);
            end
            if (Valid_i && !Ready_i) begin
                Stall_o <= sat_inc(Stall_o);
            end
        end
    end
`endif

endmodule

// File: tb/tb_demux_1_to_2_buf.sv
// Scoreboard bench for demux_1_to_2_buf: a negedge monitor models both
// channel queues and checks every output; scenario tasks add targeted checks.
module tb_demux_1_to_2_buf;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst_n;
    logic             Select;
    logic [WIDTH-1:0] Data_i;
    logic             Valid_i;
    logic             Ready_i;
    logic [WIDTH-1:0] Data_o1;
    logic             Valid_o1;
    logic             Ready_o1;
    logic [WIDTH-1:0] Data_o2;
    logic             Valid_o2;
    logic             Ready_o2;
`ifdef DEMUX_1_TO_2_BUF_STATS_EN
    logic [31:0]      Count_o1;
    logic [31:0]      Count_o2;
    logic [31:0]      Stall_o;
`endif

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] q1[$];
    logic [WIDTH-1:0] q2[$];
    int pops1 = 0;
    int pops2 = 0;

    demux_1_to_2_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Select   (Select),
        .Data_i   (Data_i),
        .Valid_i  (Valid_i),
        .Ready_i  (Ready_i),
        .Data_o1  (Data_o1),
        .Valid_o1 (Valid_o1),
        .Ready_o1 (Ready_o1),
        .Data_o2  (Data_o2),
        .Valid_o2 (Valid_o2),
        .Ready_o2 (Ready_o2)
`ifdef DEMUX_1_TO_2_BUF_STATS_EN
        ,
        .Count_o1 (Count_o1),
        .Count_o2 (Count_o2),
        .Stall_o  (Stall_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: compares outputs against the queue model, then
    // applies the handshakes that the coming rising edge will perform.
    always @(negedge clk) begin
        logic             exp_v1;
        logic             exp_v2;
        logic [WIDTH-1:0] exp_d1;
        logic [WIDTH-1:0] exp_d2;
        logic             exp_rdy;
        if (!rst_n) begin
            q1.delete();
            q2.delete();
            checks++;
            if (Valid_o1 !== 1'b0 || Valid_o2 !== 1'b0 || Data_o1 !== '0 ||
                Data_o2 !== '0 || Ready_i !== 1'b1) begin
                errors++;
                $display("FAIL reset_outputs: v1=%b v2=%b d1=%h d2=%h rdy=%b, required 0 0 0 0 1",
                         Valid_o1, Valid_o2, Data_o1, Data_o2, Ready_i);
            end
        end else begin
            exp_v1  = (q1.size() != 0);
            exp_v2  = (q2.size() != 0);
            exp_d1  = exp_v1 ? q1[0] : '0;
            exp_d2  = exp_v2 ? q2[0] : '0;
            exp_rdy = Select ? (q2.size() < DEPTH) : (q1.size() < DEPTH);
            checks++;
            if (Valid_o1 !== exp_v1 || Data_o1 !== exp_d1) begin
                errors++;
                $display("FAIL ch1_head @%0t: valid=%b data=%h, required valid=%b data=%h",
                         $time, Valid_o1, Data_o1, exp_v1, exp_d1);
            end
            checks++;
            if (Valid_o2 !== exp_v2 || Data_o2 !== exp_d2) begin
                errors++;
                $display("FAIL ch2_head @%0t: valid=%b data=%h, required valid=%b data=%h",
                         $time, Valid_o2, Data_o2, exp_v2, exp_d2);
            end
            checks++;
            if (Ready_i !== exp_rdy) begin
                errors++;
                $display("FAIL ready_i @%0t: got %b, required %b (sel=%b)",
                         $time, Ready_i, exp_rdy, Select);
            end
            if (exp_v1 && Ready_o1) begin
                void'(q1.pop_front());
                pops1++;
            end
            if (exp_v2 && Ready_o2) begin
                void'(q2.pop_front());
                pops2++;
            end
            if (Valid_i && exp_rdy) begin
                if (Select) q2.push_back(Data_i);
                else        q1.push_back(Data_i);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion before 500000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        Valid_i  = 1'b1;
        Select   = 1'b0;
        Data_i   = 32'hDEAD_BEEF;
        Ready_o1 = 1'b0;
        Ready_o2 = 1'b0;
        repeat (3) tick();
        checks++;
        if (Valid_o1 !== 1'b0 || Ready_i !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold: v1=%b rdy=%b, required 0 1", Valid_o1, Ready_i);
        end
        Valid_i = 1'b0;
        rst_n   = 1'b1;
        tick();
        checks++;
        if (Valid_o1 !== 1'b0 || Valid_o2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_nothing_written: v1=%b v2=%b, required 0 0", Valid_o1, Valid_o2);
        end
    endtask

    task automatic test_routing();
        Ready_o1 = 1'b1;
        Ready_o2 = 1'b1;
        Select   = 1'b0;
        Data_i   = 32'hA5A5_0001;
        Valid_i  = 1'b1;
        tick();
        checks++;
        if (Valid_o1 !== 1'b1 || Data_o1 !== 32'hA5A5_0001 || Valid_o2 !== 1'b0) begin
            errors++;
            $display("FAIL route_ch1: v1=%b d1=%h v2=%b, required 1 a5a50001 0",
                     Valid_o1, Data_o1, Valid_o2);
        end
        Select = 1'b1;
        Data_i = 32'h5A5A_0002;
        tick();
        Valid_i = 1'b0;
        checks++;
        if (Valid_o1 !== 1'b0 || Valid_o2 !== 1'b1 || Data_o2 !== 32'h5A5A_0002) begin
            errors++;
            $display("FAIL route_ch2: v1=%b v2=%b d2=%h, required 0 1 5a5a0002",
                     Valid_o1, Valid_o2, Data_o2);
        end
        tick();
        checks++;
        if (Valid_o2 !== 1'b0) begin
            errors++;
            $display("FAIL route_once: v2=%b, required 0", Valid_o2);
        end
    endtask

    task automatic test_full_backpressure();
        Ready_o1 = 1'b0;
        Ready_o2 = 1'b1;
        Select   = 1'b0;
        Valid_i  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            Data_i = WIDTH'(i);
            tick();
        end
        Data_i = 32'd5;
        checks++;
        if (Ready_i !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: got %b, required 0 on 5th beat", Ready_i);
        end
        tick();
        Select = 1'b1;
        Data_i = 32'h0000_00C2;
        #1;
        checks++;
        if (Ready_i !== 1'b1) begin
            errors++;
            $display("FAIL other_channel_ready: got %b, required 1", Ready_i);
        end
        tick();
        checks++;
        if (Valid_o2 !== 1'b1 || Data_o2 !== 32'h0000_00C2) begin
            errors++;
            $display("FAIL other_channel_land: v2=%b d2=%h, required 1 000000c2", Valid_o2, Data_o2);
        end
        Select = 1'b0;
        Data_i = 32'd5;
    endtask

    task automatic test_full_pop();
        int budget;
        Ready_o1 = 1'b1;
        #1;
        checks++;
        if (Ready_i !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_refuse: got %b, required 0", Ready_i);
        end
        tick();
        Ready_o1 = 1'b0;
        checks++;
        if (Ready_i !== 1'b1 || Data_o1 !== 32'd2) begin
            errors++;
            $display("FAIL full_pop_next: rdy=%b d1=%h, required 1 00000002", Ready_i, Data_o1);
        end
        tick();
        Valid_i = 1'b0;
        checks++;
        if (Ready_i !== 1'b0 || q1.size() != DEPTH) begin
            errors++;
            $display("FAIL full_pop_refill: rdy=%b depth=%0d, required 0 %0d", Ready_i, q1.size(), DEPTH);
        end
        Ready_o1 = 1'b1;
        budget = 0;
        while (q1.size() != 0 && budget < 20) begin
            tick();
            budget++;
        end
        checks++;
        if (q1.size() != 0 || Valid_o1 !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_drain: left=%0d v1=%b, required 0 0", q1.size(), Valid_o1);
        end
    endtask

    task automatic test_wrap_around();
        int base;
        int cyc;
        int budget;
        logic acc;
        base     = pops2;
        cyc      = 0;
        Ready_o2 = 1'b1;
        Select   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            Data_i  = WIDTH'(i);
            Valid_i = 1'b1;
            budget  = 0;
            do begin
                acc = Ready_i;
                tick();
                cyc++;
                budget++;
                if (cyc % 3 == 0) Ready_o2 = ~Ready_o2;
            end while (!acc && budget < 50);
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL wrap_stall: beat %0d not accepted, required acceptance within 50 cycles", i);
            end
        end
        Valid_i  = 1'b0;
        Ready_o2 = 1'b1;
        budget   = 0;
        while (q2.size() != 0 && budget < 20) begin
            tick();
            budget++;
        end
        tick();
        checks++;
        if (pops2 - base != 20 || Valid_o2 !== 1'b0) begin
            errors++;
            $display("FAIL wrap_count: delivered=%0d v2=%b, required 20 0", pops2 - base, Valid_o2);
        end
    endtask

    task automatic test_async_reset();
        Ready_o1 = 1'b0;
        Select   = 1'b0;
        Valid_i  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            Data_i = 32'hB000_0000 + WIDTH'(i);
            tick();
        end
        Valid_i = 1'b0;
        checks++;
        if (Valid_o1 !== 1'b1) begin
            errors++;
            $display("FAIL async_setup: v1=%b, required 1", Valid_o1);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (Valid_o1 !== 1'b0 || Data_o1 !== '0) begin
            errors++;
            $display("FAIL async_drop: v1=%b d1=%h, required 0 0", Valid_o1, Data_o1);
        end
`ifdef DEMUX_1_TO_2_BUF_STATS_EN
        checks++;
        if (Count_o1 !== 32'd0 || Stall_o !== 32'd0) begin
            errors++;
            $display("FAIL async_stats: count1=%0d stall=%0d, required 0 0", Count_o1, Stall_o);
        end
`endif
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (Valid_o1 !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_empty: v1=%b, required 0", Valid_o1);
        end
        Ready_o1 = 1'b1;
        Data_i   = 32'h0000_0077;
        Valid_i  = 1'b1;
        tick();
        Valid_i = 1'b0;
        checks++;
        if (Valid_o1 !== 1'b1 || Data_o1 !== 32'h0000_0077) begin
            errors++;
            $display("FAIL post_reset_push: v1=%b d1=%h, required 1 00000077", Valid_o1, Data_o1);
        end
        tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        Select   = 1'b0;
        Data_i   = '0;
        Valid_i  = 1'b0;
        Ready_o1 = 1'b0;
        Ready_o2 = 1'b0;
        test_reset();
        test_routing();
        test_full_backpressure();
        test_full_pop();
        test_wrap_around();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
